// File: rtl/mux_n_one_arbiter.sv
// Purpose: N-channel arbitrating multiplexer that moves one granted input word per cycle into a registered output stage.
// Latency: 1 cycle from acceptance (valid_in & ready_out) to the word appearing on data_out / valid_out.
// Backpressure: while valid_out & ~ready_in the output register holds and every ready_out bit is 0; a drain and a load can share a cycle.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   valid_in/data_in  per-channel request and word (channel i at data_in[i*WIDTH +: WIDTH])
//   ready_out         one-hot (or zero) combinational accept, a function of valid_in, valid_out, ready_in and reset only
//   data_out          registered word of the last accepted channel
//   valid_out         data_out holds a word that has not yet been consumed
//   ready_in          downstream consumes data_out this cycle
//   select_out        index of the channel whose word is in data_out
//
// Parameters: WIDTH data bits, CHANNELS inputs (1..16), MODE 0 = fixed priority (lowest index), 1 = round robin.

module mux_n_one_arbiter #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int MODE      = 0,
    localparam int SEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          valid_in,
    input  logic [CHANNELS*WIDTH-1:0]    data_in,
    output logic [CHANNELS-1:0]          ready_out,
    output logic [WIDTH-1:0]             data_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [SEL_WIDTH-1:0]         select_out
);

    // Output register and round-robin pointer.
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     data_q,  data_d;
    logic [SEL_WIDTH-1:0] sel_q,   sel_d;
    logic [SEL_WIDTH-1:0] ptr_q,   ptr_d;

    logic                 load;
    logic                 xfer;
    logic                 grant_vld;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic [SEL_WIDTH-1:0] search_start;
    logic [SEL_WIDTH-1:0] ptr_next;
    logic [WIDTH-1:0]     grant_word;

    // The register can take a new word when it is empty or is being drained
    // in this same cycle, which keeps throughput at one word per cycle.
    assign load = ~valid_q | ready_in;

    // Fixed priority is the round-robin search with the start pinned to 0.
    assign search_start = (MODE == 1) ? ptr_q : '0;

    // Two-pass search: first the channels at or above the start index, then
    // wrap around to the lowest requesting channel below it.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!grant_vld && valid_in[i] && (i >= int'(search_start))) begin
                grant_vld = 1'b1;
                grant_idx = SEL_WIDTH'(i);
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!grant_vld && valid_in[i]) begin
                grant_vld = 1'b1;
                grant_idx = SEL_WIDTH'(i);
            end
        end
    end

    // Accept strobe: only the granted channel, only when the register can
    // load, and never while reset is asserted (a held word is being dropped).
    always_comb begin
        ready_out = '0;
        if (!reset && load && grant_vld) begin
            for (int i = 0; i < CHANNELS; i++) begin
                ready_out[i] = (SEL_WIDTH'(i) == grant_idx);
            end
        end
    end

    assign xfer = |ready_out;

    // Word select is driven by the grant index only; data_in never reaches
    // the handshake path.
    always_comb begin
        grant_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_WIDTH'(i) == grant_idx) begin
                grant_word = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves to the channel after the one just served, wrapping at
    // CHANNELS-1 (CHANNELS need not be a power of two).
    always_comb begin
        if (int'(grant_idx) >= CHANNELS - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + SEL_WIDTH'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = grant_word;
            sel_d   = grant_idx;
            ptr_d   = ptr_next;
        end else if (ready_in) begin
            // Drain without refill: word and index stay for inspection.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign select_out = sel_q;

endmodule
